button_debounce: RTL

- Conditions a raw, bouncy push-button input so it can drive the board LED stage and other user-input logic.
- Synchronises the pad signal into the CLK domain and filters bounce with a stability counter.
- Outputs a clean debounced level, single-cycle press and release pulses, and a press-toggled level.
- Sits directly upstream of the top-level LED assignment; TOGGLE or BTN_LEVEL feeds LED.

---
 rtl/button_debounce.sv | 109 ++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchronises a bouncy push-button pad and filters it with a stability counter
// Outputs a debounced level, one-cycle press/release pulses and a press-toggled level.
module button_debounce #(
   parameter int CNT_WIDTH  = 20,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic BTN_IN,
   output logic BTN_LEVEL,
   output logic PRESS_PULSE,
   output logic RELEASE_PULSE,
   output logic TOGGLE
);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic                 IDLE_LVL = ACTIVE_LOW;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

   logic                 s1_q;
   logic                 s2_q;
   logic                 p;
   state_t               state_q;
   logic [CNT_WIDTH-1:0] cnt_q;

   // Synchroniser resets to the idle pad level so reset release never looks like a press.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         s1_q <= IDLE_LVL;
         s2_q <= IDLE_LVL;
      end else begin
         s1_q <= BTN_IN;
         s2_q <= s1_q;
      end
   end

   assign p = s2_q ^ IDLE_LVL;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q       <= RELEASED;
         cnt_q         <= '0;
         BTN_LEVEL     <= 1'b0;
         PRESS_PULSE   <= 1'b0;
         RELEASE_PULSE <= 1'b0;
         TOGGLE        <= 1'b0;
      end else begin
         PRESS_PULSE   <= 1'b0;
         RELEASE_PULSE <= 1'b0;
         case (state_q)
            RELEASED: begin
               if (p) begin
                  state_q <= PRESS_WAIT;
                  cnt_q   <= CNT_ONE;
               end else begin
                  cnt_q   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!p) begin
                  state_q <= RELEASED;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q     <= PRESSED;
                  cnt_q       <= '0;
                  BTN_LEVEL   <= 1'b1;
                  PRESS_PULSE <= 1'b1;
                  TOGGLE      <= ~TOGGLE;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            PRESSED: begin
               if (!p) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= CNT_ONE;
               end else begin
                  cnt_q   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (p) begin
                  state_q <= PRESSED;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q       <= RELEASED;
                  cnt_q         <= '0;
                  BTN_LEVEL     <= 1'b0;
                  RELEASE_PULSE <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= RELEASED;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule
